// File: rtl/fpga2hps_rd_arb.sv
// fpga2hps_rd_arb
// Two-requester read arbiter for the FPGA-to-HPS AXI3 slave port.
// Requester 0 (video scanout) and requester 1 (DMA/blitter) share the AR and
// R channels. AR is granted round-robin, limited to MAX_OUT outstanding bursts
// per requester. R beats are steered back combinationally by rid[0].
//
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   mN_req_*                burst read request (valid/ready/addr/len), N=0,1
//   mN_r*                   read beat return (valid/ready/data/last/err)
//   fpga_to_hps_ar*         AXI3 AR channel master side
//   fpga_to_hps_r*          AXI3 R channel master side
//   protocol_err            sticky: rlast seen for a requester with nothing outstanding
module fpga2hps_rd_arb #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  input  logic [3:0]  m0_req_len,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [31:0] m0_rdata,
  output logic        m0_rlast,
  output logic        m0_rerr,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  input  logic [3:0]  m1_req_len,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] m1_rdata,
  output logic        m1_rlast,
  output logic        m1_rerr,

  output logic        fpga_to_hps_arvalid,
  output logic [7:0]  fpga_to_hps_arid,
  output logic [31:0] fpga_to_hps_araddr,
  output logic [3:0]  fpga_to_hps_arlen,
  output logic [2:0]  fpga_to_hps_arsize,
  output logic [1:0]  fpga_to_hps_arburst,
  output logic [3:0]  fpga_to_hps_arcache,
  output logic [2:0]  fpga_to_hps_arprot,
  output logic [1:0]  fpga_to_hps_arlock,
  input  logic        fpga_to_hps_arready,

  input  logic        fpga_to_hps_rvalid,
  input  logic [7:0]  fpga_to_hps_rid,
  input  logic [1:0]  fpga_to_hps_rresp,
  input  logic [31:0] fpga_to_hps_rdata,
  input  logic        fpga_to_hps_rlast,
  output logic        fpga_to_hps_rready,

  output logic        protocol_err
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_ar_id;        // requester owning the AR currently held
  logic [31:0]      r_araddr;
  logic [3:0]       r_arlen;
  logic [1:0][3:0]  r_out_cnt;
  logic             r_protocol_err;

  logic [1:0]       w_elig;
  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_rready;
  logic [1:0]       w_inc;
  logic [1:0]       w_dec;

  assign w_elig[0] = m0_req_valid && (r_out_cnt[0] < MAX_OUT_C);
  assign w_elig[1] = m1_req_valid && (r_out_cnt[1] < MAX_OUT_C);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vld   = 1'b0;
    w_gnt_id    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig[0] && w_elig[1]) begin
          // Tie: the requester that did not win last time goes next.
          w_gnt_vld = 1'b1;
          w_gnt_id  = ~r_last_grant;
        end else if (w_elig[0] || w_elig[1]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = w_elig[1];
        end
        if (w_gnt_vld) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (fpga_to_hps_arready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign m0_req_ready = w_gnt_vld && !w_gnt_id;
  assign m1_req_ready = w_gnt_vld &&  w_gnt_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_ar_id      <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_vld) begin
        r_last_grant <= w_gnt_id;
        r_ar_id      <= w_gnt_id;
        r_araddr     <= w_gnt_id ? {m1_req_addr[31:2], 2'b00} : {m0_req_addr[31:2], 2'b00};
        r_arlen      <= w_gnt_id ? m1_req_len : m0_req_len;
      end
    end
  end

  // arvalid comes straight from the state register so an async reset drops it at once.
  assign fpga_to_hps_arvalid = (r_state == ST_ISSUE);
  assign fpga_to_hps_arid    = {7'b0, r_ar_id};
  assign fpga_to_hps_araddr  = r_araddr;
  assign fpga_to_hps_arlen   = r_arlen;
  assign fpga_to_hps_arsize  = 3'b010;
  assign fpga_to_hps_arburst = 2'b01;
  assign fpga_to_hps_arcache = 4'b0011;
  assign fpga_to_hps_arprot  = 3'b000;
  assign fpga_to_hps_arlock  = 2'b00;

  // R path: pure steering on rid[0], no storage.
  assign w_rready           = fpga_to_hps_rid[0] ? m1_rready : m0_rready;
  assign fpga_to_hps_rready = w_rready;
  assign m0_rvalid          = fpga_to_hps_rvalid && !fpga_to_hps_rid[0];
  assign m1_rvalid          = fpga_to_hps_rvalid &&  fpga_to_hps_rid[0];
  assign m0_rdata           = fpga_to_hps_rdata;
  assign m1_rdata           = fpga_to_hps_rdata;
  assign m0_rlast           = fpga_to_hps_rlast;
  assign m1_rlast           = fpga_to_hps_rlast;
  assign m0_rerr            = (fpga_to_hps_rresp != 2'b00);
  assign m1_rerr            = (fpga_to_hps_rresp != 2'b00);

  assign w_inc[0] = (r_state == ST_ISSUE) && fpga_to_hps_arready && !r_ar_id;
  assign w_inc[1] = (r_state == ST_ISSUE) && fpga_to_hps_arready &&  r_ar_id;
  assign w_dec[0] = fpga_to_hps_rvalid && w_rready && fpga_to_hps_rlast && !fpga_to_hps_rid[0];
  assign w_dec[1] = fpga_to_hps_rvalid && w_rready && fpga_to_hps_rlast &&  fpga_to_hps_rid[0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_cnt      <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_inc[n] && !w_dec[n]) begin
          r_out_cnt[n] <= r_out_cnt[n] + 4'd1;
        end else if (w_dec[n] && !w_inc[n] && (r_out_cnt[n] != 4'd0)) begin
          r_out_cnt[n] <= r_out_cnt[n] - 4'd1;
        end
        // A burst completing for a requester with nothing outstanding is an
        // upstream bug; the count saturates at 0 and the flag latches.
        if (w_dec[n] && (r_out_cnt[n] == 4'd0)) r_protocol_err <= 1'b1;
      end
    end
  end

  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_fpga2hps_rd_arb.sv
// tb_fpga2hps_rd_arb
// Directed test-plan scenarios followed by a random phase, all checked every
// cycle against a transaction-level reference model of the arbiter.
module tb_fpga2hps_rd_arb;

  localparam int unsigned MAX_OUT = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        m0_req_valid, m0_req_ready, m0_rvalid, m0_rready, m0_rlast, m0_rerr;
  logic [31:0] m0_req_addr, m0_rdata;
  logic [3:0]  m0_req_len;
  logic        m1_req_valid, m1_req_ready, m1_rvalid, m1_rready, m1_rlast, m1_rerr;
  logic [31:0] m1_req_addr, m1_rdata;
  logic [3:0]  m1_req_len;
  logic        arvalid, arready;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen, arcache;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        rvalid, rlast, rready;
  logic [7:0]  rid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        protocol_err;

  fpga2hps_rd_arb #(.MAX_OUT(MAX_OUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_addr(m0_req_addr), .m0_req_len(m0_req_len),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rlast(m0_rlast), .m0_rerr(m0_rerr),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_addr(m1_req_addr), .m1_req_len(m1_req_len),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rlast(m1_rlast), .m1_rerr(m1_rerr),
    .fpga_to_hps_arvalid(arvalid), .fpga_to_hps_arid(arid),
    .fpga_to_hps_araddr(araddr), .fpga_to_hps_arlen(arlen),
    .fpga_to_hps_arsize(arsize), .fpga_to_hps_arburst(arburst),
    .fpga_to_hps_arcache(arcache), .fpga_to_hps_arprot(arprot),
    .fpga_to_hps_arlock(arlock), .fpga_to_hps_arready(arready),
    .fpga_to_hps_rvalid(rvalid), .fpga_to_hps_rid(rid),
    .fpga_to_hps_rresp(rresp), .fpga_to_hps_rdata(rdata),
    .fpga_to_hps_rlast(rlast), .fpga_to_hps_rready(rready),
    .protocol_err(protocol_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: one optional pending AR transaction plus per-requester
  // outstanding-burst tallies.
  bit          mdl_busy;
  bit          mdl_id;
  logic [31:0] mdl_addr;
  logic [3:0]  mdl_len;
  bit          mdl_last;
  int          mdl_cnt [2];
  bit          mdl_perr;

  int          ar_log [$];     // arid of every AR handshake seen
  int          rdy_cnt [2];    // req_ready pulses seen per requester

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    mdl_busy = 0; mdl_id = 0; mdl_addr = '0; mdl_len = '0; mdl_last = 1;
    mdl_cnt[0] = 0; mdl_cnt[1] = 0; mdl_perr = 0;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_req_addr = '0; m0_req_len = '0; m0_rready = 0;
    m1_req_valid = 0; m1_req_addr = '0; m1_req_len = '0; m1_rready = 0;
    arready = 0; rvalid = 0; rid = '0; rresp = '0; rdata = '0; rlast = 0;
  endtask

  // Called at a falling edge with inputs already applied; checks outputs,
  // advances one clock, updates the model, and returns at the next falling edge.
  task automatic step();
    bit elig [2];
    bit gv, gid, exp_rready, inc, dec;
    #1;
    elig[0] = !mdl_busy && m0_req_valid && (mdl_cnt[0] < MAX_OUT);
    elig[1] = !mdl_busy && m1_req_valid && (mdl_cnt[1] < MAX_OUT);
    gv  = elig[0] || elig[1];
    gid = (elig[0] && elig[1]) ? !mdl_last : elig[1];
    exp_rready = rid[0] ? m1_rready : m0_rready;

    check("m0_req_ready", m0_req_ready, gv && !gid);
    check("m1_req_ready", m1_req_ready, gv && gid);
    check("arvalid", arvalid, mdl_busy);
    check("araddr", araddr, mdl_addr);
    check("arlen", arlen, mdl_len);
    check("arid", arid, {7'b0, mdl_id});
    check("ar_const", {arsize, arburst, arcache, arprot, arlock}, {3'b010, 2'b01, 4'b0011, 3'b000, 2'b00});
    check("m0_rvalid", m0_rvalid, rvalid && !rid[0]);
    check("m1_rvalid", m1_rvalid, rvalid && rid[0]);
    check("m0_rdata", m0_rdata, rdata);
    check("m1_rdata", m1_rdata, rdata);
    check("rlast_fwd", {m0_rlast, m1_rlast}, {rlast, rlast});
    check("rerr_fwd", {m0_rerr, m1_rerr}, {rresp != 0, rresp != 0});
    check("rready", rready, exp_rready);
    check("protocol_err", protocol_err, mdl_perr);

    if (arvalid && arready) ar_log.push_back(int'(arid));
    if (m0_req_ready) rdy_cnt[0]++;
    if (m1_req_ready) rdy_cnt[1]++;

    @(posedge CLK);
    for (int n = 0; n < 2; n++) begin
      inc = mdl_busy && arready && (mdl_id == n[0]);
      dec = rvalid && exp_rready && rlast && (rid[0] == n[0]);
      if (dec && mdl_cnt[n] == 0) mdl_perr = 1;
      if (inc && !dec) mdl_cnt[n]++;
      else if (dec && !inc && mdl_cnt[n] > 0) mdl_cnt[n]--;
    end
    if (gv) begin
      mdl_busy = 1;
      mdl_id   = gid;
      mdl_addr = gid ? {m1_req_addr[31:2], 2'b00} : {m0_req_addr[31:2], 2'b00};
      mdl_len  = gid ? m1_req_len : m0_req_len;
      mdl_last = gid;
    end else if (mdl_busy && arready) begin
      mdl_busy = 0;
    end
    @(negedge CLK);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 0;
    mdl_clear();
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arid", arid, 0);
    check("rst_req_ready", {m0_req_ready, m1_req_ready}, 2'b00);
    check("rst_protocol_err", protocol_err, 0);
    @(negedge CLK);
    RST_N = 1;
    ar_log.delete();
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
  endtask

  initial begin
    int n0;
    bit ok;
    RST_N = 1;
    idle_inputs();
    @(negedge CLK);

    // Single request, four-beat response.
    do_reset();
    m0_req_valid = 1; m0_req_addr = 32'h3000_0006; m0_req_len = 4'd3; arready = 1;
    step();
    m0_req_valid = 0;
    check("single_arvalid", arvalid, 1);
    check("single_araddr", araddr, 32'h3000_0004);
    check("single_arlen", arlen, 3);
    check("single_arid", arid, 8'h00);
    step();
    check("single_arvalid_drop", arvalid, 0);
    arready = 0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rid = 8'h00; m0_rready = 1; rdata = $urandom; rlast = (b == 3);
      step();
    end
    rvalid = 0; rlast = 0;
    steps(2);
    check("single_no_perr", protocol_err, 0);

    // Tie and round-robin.
    do_reset();
    m0_req_valid = 1; m1_req_valid = 1; arready = 1;
    m0_req_addr = 32'h1000_0000; m1_req_addr = 32'h2000_0010;
    steps(8);
    check("rr_count", ar_log.size(), 4);
    ok = (ar_log.size() == 4);
    for (int i = 0; i < ar_log.size(); i++) if (ar_log[i] != (i % 2)) ok = 0;
    check("rr_order", ok, 1);

    // AR backpressure.
    do_reset();
    m0_req_valid = 1; m1_req_valid = 1; arready = 0;
    m0_req_addr = 32'h0000_0abc; m0_req_len = 4'd7; m1_req_addr = 32'h0000_1230;
    steps(6);
    check("bp_arid", arid, 0);
    check("bp_araddr", araddr, 32'h0000_0abc);
    check("bp_rdy0_once", rdy_cnt[0], 1);
    check("bp_rdy1_never", rdy_cnt[1], 0);
    arready = 1;
    step();
    m0_req_valid = 0; m1_req_valid = 0;
    step();

    // Outstanding limit.
    do_reset();
    m0_req_valid = 1; arready = 1;
    steps(12);
    n0 = 0;
    foreach (ar_log[i]) if (ar_log[i] == 0) n0++;
    check("lim_m0_ars", n0, MAX_OUT);
    m1_req_valid = 1;
    ar_log.delete();
    steps(4);
    ok = (ar_log.size() == 2);
    foreach (ar_log[i]) if (ar_log[i] != 1) ok = 0;
    check("lim_m1_still_granted", ok, 1);
    m1_req_valid = 0;
    rvalid = 1; rid = 8'h00; rlast = 1; m0_rready = 1;
    step();
    rvalid = 0; rlast = 0;
    ar_log.delete();
    steps(10);
    check("lim_one_more_m0", ar_log.size(), 1);

    // R routing with interleaved IDs and toggling m1_rready.
    do_reset();
    m0_rready = 1;
    for (int b = 0; b < 8; b++) begin
      rvalid = 1; rid = (b % 2 == 0) ? 8'h01 : 8'h00; m1_rready = b[1];
      rdata = $urandom; rlast = 0; rresp = (b == 2) ? 2'b10 : 2'b00;
      step();
      if (b == 2) check("rerr_on_beat", m1_rerr, 1);
      if (b == 4) check("rerr_cleared", m1_rerr, 0);
    end
    rvalid = 0; rresp = 0;

    // Protocol error and async reset during ISSUE.
    do_reset();
    rvalid = 1; rid = 8'h00; rlast = 1; m0_rready = 1;
    step();
    rvalid = 0; rlast = 0;
    step();
    check("perr_set", protocol_err, 1);
    steps(3);
    check("perr_held", protocol_err, 1);
    m1_req_valid = 1; arready = 0;
    step();
    check("pre_rst_arvalid", arvalid, 1);
    RST_N = 0;
    #1;
    check("async_rst_arvalid", arvalid, 0);
    check("async_rst_perr", protocol_err, 0);
    mdl_clear();
    @(negedge CLK);
    RST_N = 1;
    idle_inputs();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      m0_req_valid = ($urandom_range(0, 99) < 60);
      m1_req_valid = ($urandom_range(0, 99) < 60);
      m0_req_addr  = $urandom;  m0_req_len = 4'($urandom);
      m1_req_addr  = $urandom;  m1_req_len = 4'($urandom);
      arready      = ($urandom_range(0, 99) < 50);
      rvalid       = ($urandom_range(0, 99) < 50);
      rid          = 8'($urandom);
      rresp        = 2'($urandom);
      rdata        = $urandom;
      rlast        = (mdl_cnt[rid[0]] > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
      m0_rready    = ($urandom_range(0, 99) < 70);
      m1_rready    = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
